tcdm_bank_model: RTL
====================

TCDM_BANK_MODEL -- requirements
Module: tcdm_bank_model

Interface
REQ-001 SHALL have parameter AddrMemWidth, default 8: word-address bits, giving depth 2^AddrMemWidth words.
REQ-002 SHALL have parameter DataWidth, default 32: word width in bits; a multiple of 8.
REQ-003 SHALL have parameter BeWidth, default DataWidth/8: one byte-enable bit per byte.
REQ-004 SHALL have parameter MemLatency, default 1: grant-to-rdata cycles; legal range 1..8.
REQ-005 SHALL have parameter CntWidth, default 16: width of the statistics counters.
REQ-006 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low; one clock, reset asynchronous and active-low.
REQ-008 SHALL have port req_i, input, 1 bit: bank request from the interconnect.
REQ-009 SHALL have port gnt_o, output, 1 bit: bank grant.
REQ-010 SHALL have port add_i, input, AddrMemWidth bits: word address inside the bank.
REQ-011 SHALL have port wen_i, input, 1 bit: 1 = store, 0 = load.
REQ-012 SHALL have port wdata_i, input, DataWidth bits: write data.
REQ-013 SHALL have port be_i, input, BeWidth bits: byte enables for stores.
REQ-014 SHALL have port rdata_o, output, DataWidth bits: read data.
REQ-015 SHALL have port rvalid_o, output, 1 bit: rdata_o carries a load result this cycle (bench aid only).
REQ-016 SHALL have port stall_i, input, 1 bit: forces grant low, for backpressure tests.
REQ-017 SHALL have port rd_cnt_o, output, CntWidth bits: count of granted loads.
REQ-018 SHALL have port wr_cnt_o, output, CntWidth bits: count of granted stores.
REQ-019 SHALL have port stall_cnt_o, output, CntWidth bits: count of cycles with req_i=1 and gnt_o=0.

Function
REQ-020 SHALL drive gnt_o = req_i & ~stall_i, purely combinational, with no dependence on add_i or wen_i.
REQ-021 SHALL treat a cycle with req_i=1 and gnt_o=1 as an accepted access; at most one access SHALL be accepted per cycle.
REQ-022 On an accepted store, SHALL update mem[add_i] byte i to wdata_i byte i for every i with be_i[i]=1 at the clock edge; other bytes SHALL be unchanged.
REQ-023 An accepted store with be_i=0 SHALL leave memory unchanged but SHALL still increment wr_cnt_o.
REQ-024 On an accepted load, SHALL sample mem[add_i] at the grant edge into pipeline stage 1; be_i SHALL be ignored.
REQ-025 The pipeline SHALL have MemLatency stages, each with a valid bit and a data register.
REQ-026 Each stage's data SHALL load only when the previous stage is valid; the valid bits SHALL shift every cycle.
REQ-027 rdata_o SHALL equal the last stage's data register, so a load result appears exactly MemLatency cycles after its grant cycle.
REQ-028 rvalid_o SHALL equal the last stage's valid bit.
REQ-029 rdata_o SHALL hold its last load value while no load completes; stores SHALL never change rdata_o.
REQ-030 Loads granted on consecutive cycles SHALL produce results on consecutive cycles, in order, with no bubbles.
REQ-031 For a store followed by a load to the same address on the next cycle, the load SHALL return the new data.
REQ-032 A load sampled before a later store SHALL return the old data, even if the store commits while the load is still in the pipeline.
REQ-033 Not-granted cycles (stall_i=1) SHALL change neither memory nor the pipeline, except for the normal shifting of in-flight entries.
REQ-034 rd_cnt_o and wr_cnt_o SHALL each increment by 1 per accepted access of their type.
REQ-035 stall_cnt_o SHALL increment by 1 on each cycle with req_i=1 and stall_i=1.
REQ-036 All counters SHALL wrap modulo 2^CntWidth.
REQ-037 Elaboration SHALL fail fatally if MemLatency is 0 or greater than 8, or if DataWidth is not a multiple of 8.

Reset
REQ-038 While rst_ni=0, SHALL clear all memory words, pipeline valid bits, pipeline data, and counters to 0; rdata_o=0, rvalid_o=0, counter outputs=0.
REQ-039 gnt_o SHALL remain combinational and follow REQ-020 during reset, but no access SHALL take effect while rst_ni=0.
REQ-040 Assertion of reset mid-operation SHALL discard in-flight loads: no rvalid_o after release for loads granted before reset.

Verification
REQ-041 Bench SHALL cover: MemLatency=1; store 0xDEADBEEF, be=0xF, to addr 5, then load addr 5 on the next cycle -> rdata_o=0xDEADBEEF and rvalid_o=1 one cycle after the load grant; rd_cnt_o=1, wr_cnt_o=1.
REQ-042 Bench SHALL cover: partial store 0x000000AA with be=0x1 over word 0x11223344 -> load returns 0x112233AA.
REQ-043 Bench SHALL cover: MemLatency=3; back-to-back loads of addrs 1, 2, 3 holding 0xA, 0xB, 0xC -> rdata_o shows 0xA, 0xB, 0xC on cycles +3, +4, +5 with rvalid_o high for 3 cycles.
REQ-044 Bench SHALL cover: stall_i=1 for 4 cycles with req_i=1 -> gnt_o=0, stall_cnt_o=4, memory and counters otherwise unchanged.
REQ-045 Bench SHALL cover: MemLatency=2; load addr 7 (value 0x1), store 0x2 to addr 7 the next cycle -> the load returns 0x1, and a later load returns 0x2.
REQ-046 Bench SHALL cover: reset asserted one cycle after a load grant with MemLatency=2 -> no rvalid_o after release, rdata_o=0, and all counters 0.

Source files
------------

// File: rtl/tcdm_bank_model.sv
// Purpose: single-port TCDM bank model with byte-enabled stores, a fixed-latency read pipeline and access statistics.
// Latency: load data appears on rdata_o exactly MemLatency cycles after its grant cycle; stores commit at the grant edge.
// Backpressure: gnt_o = req_i & ~stall_i (combinational); a stalled request has no effect and is counted in stall_cnt_o.
module tcdm_bank_model #(
    parameter int unsigned AddrMemWidth = 8,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned BeWidth      = DataWidth / 8,
    parameter int unsigned MemLatency   = 1,
    parameter int unsigned CntWidth     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [AddrMemWidth-1:0] add_i,
    input  logic                    wen_i,
    input  logic [DataWidth-1:0]    wdata_i,
    input  logic [BeWidth-1:0]      be_i,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    rvalid_o,
    input  logic                    stall_i,
    output logic [CntWidth-1:0]     rd_cnt_o,
    output logic [CntWidth-1:0]     wr_cnt_o,
    output logic [CntWidth-1:0]     stall_cnt_o
);

    localparam int unsigned Depth = 1 << AddrMemWidth;

    // Illegal configurations stop elaboration outright.
    if (MemLatency < 1 || MemLatency > 8) begin : g_bad_latency
        $fatal(1, "tcdm_bank_model: MemLatency must be in 1..8");
    end
    if ((DataWidth % 8) != 0) begin : g_bad_width
        $fatal(1, "tcdm_bank_model: DataWidth must be a multiple of 8");
    end
    if (BeWidth != DataWidth / 8) begin : g_bad_be
        $fatal(1, "tcdm_bank_model: BeWidth must equal DataWidth/8");
    end

    logic                 load_acc;
    logic                 store_acc;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] mem_d [Depth];

    logic [MemLatency-1:0] vld_q;
    logic [MemLatency-1:0] vld_d;
    logic [DataWidth-1:0]  dat_q [MemLatency];
    logic [DataWidth-1:0]  dat_d [MemLatency];

    logic [CntWidth-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CntWidth-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CntWidth-1:0]  stall_cnt_q, stall_cnt_d;

    // Grant never looks at address or direction, only at stall_i.
    assign gnt_o     = req_i & ~stall_i;
    assign load_acc  = gnt_o & ~wen_i;
    assign store_acc = gnt_o & wen_i;

    // Byte-merge an accepted store into the addressed word; be_i=0 leaves the word intact.
    always_comb begin
        mem_d = mem_q;
        if (store_acc) begin
            for (int b = 0; b < int'(BeWidth); b++) begin
                if (be_i[b]) begin
                    mem_d[add_i][8*b +: 8] = wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 samples the array (pre-store value), later stages copy only behind a valid entry.
    always_comb begin
        vld_d    = '0;
        dat_d    = dat_q;
        vld_d[0] = load_acc;
        if (load_acc) begin
            dat_d[0] = mem_q[add_i];
        end
        for (int s = 1; s < int'(MemLatency); s++) begin
            vld_d[s] = vld_q[s-1];
            if (vld_q[s-1]) begin
                dat_d[s] = dat_q[s-1];
            end
        end
    end

    // Statistics counters, wrapping naturally at 2^CntWidth.
    always_comb begin
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (load_acc) begin
            rd_cnt_d = rd_cnt_q + CntWidth'(1);
        end
        if (store_acc) begin
            wr_cnt_d = wr_cnt_q + CntWidth'(1);
        end
        if (req_i && stall_i) begin
            stall_cnt_d = stall_cnt_q + CntWidth'(1);
        end
    end

    // Memory array state; reset clears every word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Pipeline and counter state; reset drops any in-flight loads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int s = 0; s < int'(MemLatency); s++) begin
                dat_q[s] <= '0;
            end
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            dat_q       <= dat_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rdata_o     = dat_q[MemLatency-1];
    assign rvalid_o    = vld_q[MemLatency-1];
    assign rd_cnt_o    = rd_cnt_q;
    assign wr_cnt_o    = wr_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule
